// File: rtl/demux4_router.sv
// demux4_router: 1-to-4 demultiplexer steering one valid/ready input stream into four per-channel FIFOs.
// Latency: a word accepted at edge N shows on out_valid/out_data after edge N when its FIFO was empty. There is no bypass.
// Backpressure: in_ready = ~full[in_s] and comes only from registered counts. A stalled channel blocks only words for that channel.
// Ports: clk, rst (sync, active-high) | in_valid/in_ready/in_data/in_s (input stream, in_s = channel)
//        out_valid[3:0]/out_ready[3:0]/out_data[4*DATA_W] (channel k on [k*DATA_W +: DATA_W]) | full[3:0]
// Optional macro DEMUX4_ROUTER_STAT_EN adds stat_cnt[63:0]: a 16-bit accepted-word counter per channel.

module demux4_router_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [W-1:0]                 dat_i,
  input  logic                         pop_i,
  output logic [W-1:0]                 head_o,
  output logic [$clog2(DEPTH+1)-1:0]   cnt_o
);
  // Generic per-channel FIFO. The caller gates push with ~full and pop with valid.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= dat_i;
        wr_q        <= wr_q + PW'(1);  // DEPTH is a power of two, so the pointer wraps on its own
      end
      if (pop_i) rd_q <= rd_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

  assign head_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;
endmodule

module demux4_router #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [1:0]            in_s,
  output logic [3:0]            out_valid,
  input  logic [3:0]            out_ready,
  output logic [4*DATA_W-1:0]   out_data,
  output logic [3:0]            full
`ifdef DEMUX4_ROUTER_STAT_EN
  ,
  output logic [63:0]           stat_cnt
`endif
);
  localparam int CW = $clog2(DEPTH+1);

  logic [3:0] push, pop;
  logic       accept;

  // in_ready looks only at the registered full flag of the selected channel.
  // This keeps out_ready off the input timing path.
  assign in_ready = ~full[in_s];
  assign accept   = in_valid & in_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic [CW-1:0] cnt;

    assign push[k] = accept & (in_s == 2'(k));
    assign pop[k]  = out_valid[k] & out_ready[k];

    demux4_router_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (push[k]),
      .dat_i  (in_data),
      .pop_i  (pop[k]),
      .head_o (out_data[k*DATA_W +: DATA_W]),
      .cnt_o  (cnt)
    );

    assign out_valid[k] = (cnt != '0);
    assign full[k]      = (cnt == CW'(DEPTH));
  end

`ifdef DEMUX4_ROUTER_STAT_EN
  logic [15:0] stat_q [4];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++)
        if (push[i]) stat_q[i] <= stat_q[i] + 16'd1;  // wraps FFFF -> 0
    end
  end

  assign stat_cnt = {stat_q[3], stat_q[2], stat_q[1], stat_q[0]};
`endif
endmodule

// File: tb/tb_demux4_router.sv
module tb_demux4_router;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic [1:0]         in_s = '0;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready = '0;
  logic [4*DATA_W-1:0] out_data;
  logic [3:0]         full;
`ifdef DEMUX4_ROUTER_STAT_EN
  logic [63:0]        stat_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of pending words per channel, plus accepted-word counters.
  logic [DATA_W-1:0] q [4][$];
  logic [15:0]       stat_m [4];

  demux4_router #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_s      (in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .full      (full)
`ifdef DEMUX4_ROUTER_STAT_EN
    ,
    .stat_cnt  (stat_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor and scoreboard. At every negedge it compares the DUT against the queues.
  // It then applies the handshakes the upcoming edge will perform: pops first, then the push.
  always @(negedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        q[k].delete();
        stat_m[k] = '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(q[k].size() != 0));
        chk($sformatf("full[%0d]", k), 64'(full[k]), 64'(q[k].size() == DEPTH));
        if (out_valid[k] && q[k].size() != 0)
          chk($sformatf("out_data[%0d]", k), 64'(out_data[k*DATA_W +: DATA_W]), 64'(q[k][0]));
      end
      chk("in_ready", 64'(in_ready), 64'(q[in_s].size() < DEPTH));
      begin
        automatic bit acc = in_valid && (q[in_s].size() < DEPTH);
        for (int k = 0; k < 4; k++)
          if (out_ready[k] && q[k].size() != 0) void'(q[k].pop_front());
        if (acc) begin
          q[in_s].push_back(in_data);
          stat_m[in_s] = stat_m[in_s] + 16'd1;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [1:0] s, input logic [DATA_W-1:0] d, input logic [3:0] ordy);
    @(posedge clk); #1;
    in_valid = v; in_s = s; in_data = d; out_ready = ordy;
  endtask

  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; in_s = 2'd2; in_data = 8'hAA; out_ready = '0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    logic held;
    logic [DATA_W-1:0] base;

    do_reset(2);
    drive(0, 0, 0, 4'h0);
    @(negedge clk);
    chk("post_rst_empty", 64'(out_valid), 64'd0);

    // Steering: one word per channel on consecutive cycles.
    drive(1, 0, 8'h10, 4'hF);
    drive(1, 1, 8'h21, 4'hF);
    drive(1, 2, 8'h32, 4'hF);
    drive(1, 3, 8'h43, 4'hF);
    drive(0, 0, 0, 4'hF);
    drive(0, 0, 0, 4'hF);

    // Full/backpressure on channel 1.
    drive(1, 1, 8'h01, 4'h0);
    drive(1, 1, 8'h02, 4'h0);
    drive(1, 1, 8'h03, 4'h0);
    @(negedge clk);
    chk("full1_set", 64'(full), 64'b0010);
    chk("full1_refuse", 64'(in_ready), 64'd0);
    drive(1, 3, 8'h77, 4'h0);
    @(negedge clk);
    chk("ch3_accept_while_ch1_full", 64'(in_ready), 64'd1);

    // Full with a pop: the push is refused this cycle and accepted the next.
    drive(1, 1, 8'h03, 4'b0010);
    @(negedge clk);
    chk("full_pop_refuse", 64'(in_ready), 64'd0);
    drive(1, 1, 8'h03, 4'b0000);
    @(negedge clk);
    chk("after_pop_ready", 64'(in_ready), 64'd1);
    drive(0, 0, 0, 4'b1010);
    repeat (4) drive(0, 0, 0, 4'hF);

    // Simultaneous push/pop on channel 0 with pointer wrap.
    drive(1, 0, 8'h50, 4'h0);
    for (int i = 0; i < 10; i++) drive(1, 0, 8'h55 + 8'(i), 4'b0001);
    drive(0, 0, 0, 4'hF);
    drive(0, 0, 0, 4'hF);

    // Randomized traffic. A refused word is held stable until it is accepted.
    held = 1'b0;
    for (int n = 0; n < 800; n++) begin
      @(posedge clk); #1;
      if (!held) begin
        in_valid = ($urandom_range(0, 9) < 7);
        in_s     = 2'($urandom_range(0, 3));
        in_data  = 8'($urandom);
      end
      out_ready = 4'($urandom);
      @(negedge clk);
      held = in_valid & ~in_ready;
    end
    drive(0, 0, 0, 4'hF);
    repeat (8) drive(0, 0, 0, 4'hF);
    @(negedge clk);
    chk("drain_empty", 64'(out_valid), 64'd0);

    // Reset in the middle of a transfer discards buffered words.
    drive(1, 2, 8'h99, 4'h0);
    drive(1, 2, 8'h9A, 4'h0);
    do_reset(1);
    drive(0, 0, 0, 4'hF);
    @(negedge clk);
    chk("mid_rst_discard", 64'(out_valid), 64'd0);

`ifdef DEMUX4_ROUTER_STAT_EN
    base = 8'h00;
    for (int n = 0; n < 70000; n++) begin
      drive(1, 2, base, 4'hF);
      base = base + 8'd1;
    end
    drive(0, 0, 0, 4'hF);
    @(negedge clk);
    chk("stat_model", stat_cnt, {stat_m[3], stat_m[2], stat_m[1], stat_m[0]});
    chk("stat_70000", stat_cnt, {16'd0, 16'd4464, 16'd0, 16'd0});
`else
    base = 8'h00;
    chk("base_unused", 64'(base), 64'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/demux4_router.md
Name: demux4_router

Overview:
- 1-to-4 demultiplexer: the receive-side counterpart of the team's 4:1 mux.
- Accepts one data word per cycle on a single valid/ready input and steers it to one of four output channels selected by a 2-bit select.
- Each output channel has its own small FIFO, so a stalled channel never blocks words going to other channels.
- Sits after a shared bus and fans traffic out to four independent consumers.

Parameters:
- DATA_W, 8: width of each data word.
- DEPTH, 2: entries per channel FIFO. Power of two, 2..16.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word present.
- in_ready  output  1  input word will be accepted this cycle.
- in_data  input  DATA_W  input word.
- in_s  input  2  destination channel, 0..3; sampled with in_data.
- out_valid  output  4  bit k: channel k head word valid.
- out_ready  input  4  bit k: consumer k takes head word.
- out_data  output  4*DATA_W  channel k word on bits [k*DATA_W +: DATA_W].
- full  output  4  bit k: channel k FIFO holds DEPTH words.

Behaviour:
- Reset: synchronous, active-high, dominates all other inputs.
  - All FIFO counts, read pointers, write pointers and storage are cleared.
  - After reset: out_valid=0, full=0, out_data=0.
  - Reset mid-transfer discards all buffered words. No handshake completes in the reset cycle.
- Input handshake:
  - in_ready = ~full[in_s]. It is combinational from in_s and registered count only; there is no path from out_ready to in_ready.
  - A word is accepted when in_valid & in_ready at a clk edge. It is written to the FIFO tail of channel in_s.
  - in_ready may be low while in_valid is low. The source holds in_data/in_s stable while in_valid & ~in_ready.
- Output handshake, per channel k:
  - out_valid[k] = (count_k != 0). out_data slice k = FIFO head of k.
  - Pop occurs when out_valid[k] & out_ready[k] at a clk edge.
  - out_ready[k] while out_valid[k]=0 has no effect.
- Latency: a word accepted at edge N is visible on out_valid/out_data at the output of edge N (next cycle) when the FIFO was empty. There is no bypass path.
- Ordering: FIFO order per channel. No ordering is guaranteed across channels.
- Per-channel count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: count unchanged, head advances, tail written.
- Full boundary:
  - Channel full with a pop that cycle: in_ready for that channel stays 0, because it is based on registered count. The push is refused.
  - After the pop, full clears the following cycle.
- Empty boundary: a push into an empty FIFO makes out_valid[k]=1 next cycle. A same-cycle pop is impossible because out_valid was 0.
- Pointers: log2(DEPTH)-bit, wrapping DEPTH-1 -> 0 naturally.
- full[k] = (count_k == DEPTH), registered-derived.
- Channels are fully independent: simultaneous pops on all four channels plus one push are legal in one cycle.

Optional Feature:
- Macro: DEMUX4_ROUTER_STAT_EN.
- Defined:
  - Adds output port stat_cnt, 64 bits: four 16-bit counters. Channel k is on bits [k*16 +: 16].
  - Each counter increments on every word accepted for that channel.
  - Wraps 16'hFFFF -> 0. Cleared by rst.
  - Refused words (in_valid & ~in_ready) are not counted.
- Undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1, in_s=2, in_data=8'hAA -> out_valid=4'b0000, full=0, out_data=0; nothing stored after rst drops.
- Steering: out_ready=4'hF; send 8'h10/s=0, 8'h21/s=1, 8'h32/s=2, 8'h43/s=3 on consecutive cycles -> each appears on its slice exactly one cycle after acceptance, only that out_valid bit high.
- Full/backpressure: out_ready=0; push 8'h01, 8'h02 to ch1 (DEPTH=2) -> full[1]=1; third push to ch1 gets in_ready=0; push to ch3 the same cycle still accepted.
- Full-with-pop: ch1 full, drive out_ready[1]=1 and push to ch1 -> push refused that cycle; head 8'h01 popped; next cycle in_ready=1 and push accepted; pop order is 01, 02, then the new word.
- Simultaneous push/pop: ch0 holding 1 word, push 8'h55 to ch0 with out_ready[0]=1 -> count stays 1; next head is 8'h55; pointer wrap is exercised over 10 iterations.
- STAT_EN: 70000 accepted words to ch2 -> stat_cnt[47:32] = 70000 mod 65536 = 4464; other counters 0; refused words not counted.
